// File: rtl/m_seq_pkg.sv
// Shared constants, reference-sequence generator and correlator state type
// for the M-sequence chip link.
package m_seq_pkg;

  localparam int                    MSEQ_LENGTH    = 6;
  localparam int                    MSEQ_N         = 63;
  localparam logic [MSEQ_LENGTH-1:0] MSEQ_POLYNOME = 6'b000011;
  localparam logic [MSEQ_LENGTH-1:0] MSEQ_SEED     = 6'b101010;
  localparam int                    MSEQ_HOLD      = 3;
  localparam int                    MSEQ_THRESHOLD = 60;

  typedef enum logic [1:0] {IDLE, FILL, TRACK, LOCK} corr_state_t;

  // First chip emitted lands in the MSB, matching the window's oldest sample.
  function automatic logic [MSEQ_N-1:0] gen_mseq(input logic [MSEQ_LENGTH-1:0] poly,
                                                 input logic [MSEQ_LENGTH-1:0] seed);
    logic [MSEQ_LENGTH-1:0] phase;
    logic [MSEQ_N-1:0]      seq;
    phase = seed;
    seq   = '0;
    for (int i = 0; i < MSEQ_N; i++) begin
      seq[MSEQ_N-1-i] = phase[0];
      phase           = {^(poly & phase), phase[MSEQ_LENGTH-1:1]};
    end
    return seq;
  endfunction

endpackage

// File: rtl/m_seq_correlator_popcount_reg.sv
// Correlation stage: combinational count of set bits plus a registered copy
// loaded when a trusted window is being scored.
module popcount_reg #(
  parameter int N = 63,
  parameter int W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] bits,
  output logic [W-1:0] count_now,
  output logic [W-1:0] count
);

  always_comb begin
    count_now = '0;
    for (int i = 0; i < N; i++) count_now = count_now + W'(bits[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count <= '0;
    else if (load) count <= count_now;
  end

endmodule

// File: rtl/m_seq_correlator.sv
// Sliding correlator: samples one chip per hold period into an N-bit window
// and pulses detect when the window matches the reference, true or inverted.
module m_seq_correlator
  import m_seq_pkg::*;
#(
  parameter int                N         = MSEQ_N,
  parameter int                LENGTH    = $clog2(N),
  parameter logic [LENGTH-1:0] POLYNOME  = MSEQ_POLYNOME,
  parameter logic [LENGTH-1:0] SEED      = MSEQ_SEED,
  parameter int                HOLD      = MSEQ_HOLD,
  parameter int                THRESHOLD = MSEQ_THRESHOLD
) (
  input  logic            clkin,
  input  logic            rstn,
  input  logic            chip_i,
  input  logic            chip_en_i,
  output logic [LENGTH:0] match_o,
  output logic            match_valid_o,
  output logic            detect_o,
  output logic            inverted_o,
  output logic            busy_o
);

  localparam int                CW        = LENGTH + 1;
  localparam int                HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [N-1:0]      REF       = gen_mseq(POLYNOME, SEED);
  localparam logic [HW-1:0]     HOLD_MID  = HW'(HOLD / 2);
  localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD - 1);
  localparam logic [CW-1:0]     FILL_LAST = CW'(N - 1);
  localparam logic [LENGTH-1:0] LOCK_LAST = LENGTH'(N - 2);
  localparam logic [CW-1:0]     HI_TH     = CW'(THRESHOLD);
  localparam logic [CW-1:0]     LO_TH     = CW'(N - THRESHOLD);

  corr_state_t       state_reg, state_next;
  logic [HW-1:0]     hold_reg, hold_next;
  logic [CW-1:0]     fill_reg, fill_next;
  logic [LENGTH-1:0] lock_reg, lock_next;
  logic [N-1:0]      window_reg;
  logic              pend_reg, pend_next;
  logic              valid_reg, detect_reg, detect_next;
  logic              inverted_reg, inverted_next;
  logic [CW-1:0]     agree_now;
  logic              sample, hit_true, hit_inv;

  assign sample = chip_en_i && (hold_reg == HOLD_MID);

  // Agreement count equals N minus the popcount of window ^ REF.
  popcount_reg #(.N(N), .W(CW)) u_popcount (
    .clk       (clkin),
    .rst_n     (rstn),
    .load      (pend_reg),
    .bits      (~(window_reg ^ REF)),
    .count_now (agree_now),
    .count     (match_o)
  );

  assign hit_true = (agree_now >= HI_TH);
  assign hit_inv  = (agree_now <= LO_TH);

  always_comb begin
    state_next    = state_reg;
    hold_next     = (!chip_en_i || hold_reg == HOLD_LAST) ? '0 : hold_reg + 1'b1;
    fill_next     = fill_reg;
    lock_next     = lock_reg;
    pend_next     = 1'b0;
    detect_next   = 1'b0;
    inverted_next = inverted_reg;
    if (!chip_en_i) begin
      // A score already in flight is still reported, but never as a detection.
      state_next = IDLE;
      fill_next  = '0;
      lock_next  = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          state_next = FILL;
          fill_next  = {{(CW-1){1'b0}}, sample};
        end
        FILL: begin
          if (sample) begin
            fill_next = fill_reg + 1'b1;
            if (fill_reg == FILL_LAST) begin
              state_next = TRACK;
              pend_next  = 1'b1;
            end
          end
        end
        TRACK: begin
          pend_next = sample;
          if (pend_reg && (hit_true || hit_inv)) begin
            detect_next   = 1'b1;
            inverted_next = !hit_true;
            state_next    = LOCK;
            lock_next     = '0;
          end
        end
        LOCK: begin
          pend_next = sample;
          if (pend_reg) begin
            if (lock_reg == LOCK_LAST) state_next = TRACK;
            else                       lock_next  = lock_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      hold_reg     <= '0;
      fill_reg     <= '0;
      lock_reg     <= '0;
      window_reg   <= '0;
      pend_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      detect_reg   <= 1'b0;
      inverted_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_reg     <= hold_next;
      fill_reg     <= fill_next;
      lock_reg     <= lock_next;
      pend_reg     <= pend_next;
      valid_reg    <= pend_reg;
      detect_reg   <= detect_next;
      inverted_reg <= inverted_next;
      if (sample) window_reg <= {window_reg[N-2:0], chip_i};
    end
  end

  assign match_valid_o = valid_reg;
  assign detect_o      = detect_reg;
  assign inverted_o    = inverted_reg;
  assign busy_o        = (state_reg != IDLE);

endmodule

// File: tb/tb_m_seq_correlator.sv
// Self-checking bench for m_seq_correlator: directed sequences plus random
// traffic, scored every cycle against a sample-level reference model.
module tb_m_seq_correlator;

  localparam int N    = 63;
  localparam int L    = 6;
  localparam int HOLD = 3;
  localparam int TH   = 60;
  localparam int POLY = 6'b000011;
  localparam int SEED = 6'b101010;

  logic       clkin = 1'b0;
  logic       rstn = 1'b0;
  logic       chip_i = 1'b0;
  logic       chip_en_i = 1'b0;
  logic [L:0] match_o;
  logic       match_valid_o, detect_o, inverted_o, busy_o;

  m_seq_correlator dut (
    .clkin         (clkin),
    .rstn          (rstn),
    .chip_i        (chip_i),
    .chip_en_i     (chip_en_i),
    .match_o       (match_o),
    .match_valid_o (match_valid_o),
    .detect_o      (detect_o),
    .inverted_o    (inverted_o),
    .busy_o        (busy_o)
  );

  always #5 clkin = ~clkin;

  int errors = 0;
  int checks = 0;
  int det_seen = 0;

  // Reference model state, expressed in samples rather than RTL registers.
  bit refseq[N];
  bit win[$];
  bit prev_en, pend, det_have;
  int run, nsamp, pend_idx, pend_match, last_det;
  bit exp_valid, exp_det, exp_inv, exp_busy;
  int exp_match;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic gen_ref();
    int ph, fb;
    ph = SEED;
    for (int i = 0; i < N; i++) begin
      refseq[i] = bit'(ph & 1);
      fb        = $countones(ph & POLY) & 1;
      ph        = (ph >> 1) | (fb << (L - 1));
    end
  endtask

  task automatic model_reset();
    win.delete();
    prev_en = 0; pend = 0; det_have = 0;
    run = 0; nsamp = 0; pend_idx = 0; pend_match = 0; last_det = 0;
    exp_valid = 0; exp_det = 0; exp_inv = 0; exp_busy = 0; exp_match = 0;
  endtask

  task automatic model_cycle(input bit c, input bit e);
    bit smp;
    int m;
    smp = 0;
    if (e) begin
      run = prev_en ? run + 1 : 0;
      smp = ((run % HOLD) == HOLD / 2);
    end
    exp_valid = pend;
    exp_det   = 0;
    if (pend) begin
      exp_match = pend_match;
      if (e && (!det_have || pend_idx - last_det >= N) &&
          (pend_match >= TH || pend_match <= N - TH)) begin
        exp_det  = 1;
        exp_inv  = (pend_match <= N - TH);
        det_have = 1;
        last_det = pend_idx;
      end
    end
    pend = 0;
    if (!e) begin
      nsamp    = 0;
      det_have = 0;
    end
    if (smp) begin
      win.push_back(c);
      if (win.size() > N) void'(win.pop_front());
      nsamp++;
      if (nsamp >= N) begin
        m = 0;
        for (int j = 0; j < N; j++) if (win[j] == refseq[j]) m++;
        pend       = 1;
        pend_idx   = nsamp;
        pend_match = m;
      end
    end
    exp_busy = e;
    prev_en  = e;
  endtask

  task automatic step(input bit c, input bit e);
    chip_i    = c;
    chip_en_i = e;
    model_cycle(c, e);
    @(posedge clkin);
    @(negedge clkin);
    check("valid", 32'(match_valid_o), 32'(exp_valid));
    check("detect", 32'(detect_o), 32'(exp_det));
    check("inverted", 32'(inverted_o), 32'(exp_inv));
    check("busy", 32'(busy_o), 32'(exp_busy));
    check("match", 32'(match_o), 32'(exp_match));
    if (detect_o === 1'b1) det_seen++;
  endtask

  task automatic send_chip(input bit c);
    for (int k = 0; k < HOLD; k++) step(c, 1'b1);
  endtask

  task automatic drop(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0);
  endtask

  task automatic send_seq(input bit inv, input int n_flip);
    bit flip[N];
    int k, p;
    for (int i = 0; i < N; i++) flip[i] = 0;
    k = 0;
    while (k < n_flip) begin
      p = $urandom_range(N - 1);
      if (!flip[p]) begin
        flip[p] = 1;
        k++;
      end
    end
    for (int i = 0; i < N; i++) send_chip(refseq[i] ^ inv ^ flip[i]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_match"}, 32'(match_o), 32'd0);
    check({tag, "_valid"}, 32'(match_valid_o), 32'd0);
    check({tag, "_detect"}, 32'(detect_o), 32'd0);
    check({tag, "_inverted"}, 32'(inverted_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  task automatic apply_reset();
    #2;
    rstn      = 1'b0;
    chip_en_i = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(posedge clkin);
    @(negedge clkin);
    rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    gen_ref();
    model_reset();

    // Power-on reset
    rstn = 1'b0;
    repeat (2) @(posedge clkin);
    @(negedge clkin);
    check_zero("reset");
    rstn = 1'b1;
    drop(4);

    // Aligned: random preamble, then two back-to-back sequences
    n = $urandom_range(5, 20);
    for (int i = 0; i < n; i++) send_chip(bit'($urandom_range(0, 1)));
    det_seen = 0;
    send_seq(1'b0, 0);
    check("align_match", 32'(match_o), 32'd63);
    check("align_detect", 32'(detect_o), 32'd1);
    check("align_inv", 32'(inverted_o), 32'd0);
    send_seq(1'b0, 0);
    check("lock_match", 32'(match_o), 32'd63);
    check("lock_detect", 32'(detect_o), 32'd1);
    check("lock_count", 32'(det_seen), 32'd2);
    drop(4);

    // Inverted stream, then a reset in the middle of the following traffic
    send_seq(1'b1, 0);
    check("inv_match", 32'(match_o), 32'd0);
    check("inv_detect", 32'(detect_o), 32'd1);
    check("inv_inverted", 32'(inverted_o), 32'd1);
    for (int i = 0; i < 30; i++) send_chip(bit'($urandom_range(0, 1)));
    apply_reset();
    drop(3);
    send_seq(1'b0, 0);
    check("refill_match", 32'(match_o), 32'd63);
    check("refill_detect", 32'(detect_o), 32'd1);
    check("refill_inv", 32'(inverted_o), 32'd0);
    drop(4);

    // Noise at the threshold boundary
    send_seq(1'b0, 3);
    check("noise3_match", 32'(match_o), 32'd60);
    check("noise3_detect", 32'(detect_o), 32'd1);
    drop(4);
    send_seq(1'b0, 4);
    check("noise4_match", 32'(match_o), 32'd59);
    check("noise4_detect", 32'(detect_o), 32'd0);
    drop(4);

    // Dropout after 40 samples, then a full restart
    for (int i = 0; i < 40; i++) send_chip(refseq[i]);
    drop(5);
    send_seq(1'b0, 0);
    check("dropout_match", 32'(match_o), 32'd63);
    check("dropout_detect", 32'(detect_o), 32'd1);
    drop(4);

    // Enable falls on the cycle the final score is evaluated
    for (int i = 0; i < N - 1; i++) send_chip(refseq[i]);
    step(refseq[N-1], 1'b1);
    step(refseq[N-1], 1'b1);
    step(refseq[N-1], 1'b0);
    check("lastfall_valid", 32'(match_valid_o), 32'd1);
    check("lastfall_match", 32'(match_o), 32'd63);
    check("lastfall_detect", 32'(detect_o), 32'd0);
    drop(4);

    // Random chips with sporadic enable drops
    for (int i = 0; i < 900; i++)
      step(bit'($urandom_range(0, 1)), ($urandom_range(0, 99) < 97));
    drop(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m_seq_correlator.md
# m_seq_correlator

Receive-side sliding correlator for the M-sequence chip stream. It sits directly downstream of the M-sequence generator and consumes the generator's `out` and `strobe_o` lines. Each chip is sampled once per hold period into an N-bit window, and the window is correlated against the elaborated reference sequence. The block flags full-sequence alignment, true or inverted, with a one-cycle detect pulse.

## Interface
- `POLYNOME`, 6'b000011, LFSR taps without the leading "1"; must match the generator.
- `SEED`, 6'b101010, LFSR start phase of the reference; nonzero.
- `N`, 63, sequence length (2^LENGTH − 1).
- `LENGTH`, $clog2(N), LFSR width.
- `HOLD`, 3, clock cycles per chip; ≥1.
- `THRESHOLD`, 60, minimum matching chips for detection; N/2 < THRESHOLD ≤ N.
- `clkin`  in  1  clock.
- `rstn`  in  1  asynchronous active-low reset.
- `chip_i`  in  1  chip value (generator `out`).
- `chip_en_i`  in  1  stream active (generator `strobe_o`).
- `match_o`  out  LENGTH+1  registered count of matching chips, 0..N.
- `match_valid_o`  out  1  one-cycle pulse: `match_o` updated.
- `detect_o`  out  1  one-cycle pulse: alignment found.
- `inverted_o`  out  1  polarity of last detection; 1 = inverted sequence.
- `busy_o`  out  1  high in FILL/TRACK/LOCK.

## Operation
- REF[N-1:0] is a constant: the first N LFSR output bits from SEED. REF[N-1] is the first chip emitted. Shift rule: out = phase[0], phase ← {^(POLYNOME & phase), phase[LENGTH-1:1]}.
- Sampling:
  - The hold counter restarts at 0 on the first cycle `chip_en_i` is seen high.
  - A sample is taken when the counter equals HOLD/2 (integer division). The counter wraps at HOLD−1.
  - On each sample: window ← {window[N-2:0], chip_i}.
- Correlation: match = N − popcount(window ^ REF), registered one cycle after the window update.
- FSM:
  - IDLE: `chip_en_i`=1 → FILL, with fill counter and hold counter cleared.
  - FILL: counts samples. When the fill counter reaches N, go to TRACK; the first `match_valid_o` is produced from the N-th sample.
  - TRACK: `match_valid_o` pulses once per sample.
    - match ≥ THRESHOLD → `detect_o`=1, `inverted_o`=0, go to LOCK.
    - match ≤ N−THRESHOLD → `detect_o`=1, `inverted_o`=1, go to LOCK.
  - LOCK: `match_valid_o` continues; `detect_o` is suppressed for the next N−1 samples, then the block returns to TRACK.
  - Any state, `chip_en_i`=0 → IDLE. The fill counter clears; the window is retained but is not trusted.
- Simultaneous events: `chip_en_i` falling on a sample cycle means the sample is discarded. A pending match registered in that cycle still emits `match_valid_o`, but never `detect_o`.

## Timing
- Reset (async assert, sync-style release on `clkin`):
  - `match_o`=0, `match_valid_o`=0, `detect_o`=0, `inverted_o`=0, `busy_o`=0.
  - State = IDLE; window, counters and lockout cleared.
- Latency: sample cycle s → window updated at s+1 → `match_o`, `match_valid_o` and `detect_o` registered at s+2.
- `busy_o` rises one cycle after `chip_en_i` is first seen high. It falls one cycle after `chip_en_i` is seen low.
- `detect_o` and `match_valid_o` are single-cycle pulses at most once per HOLD cycles.
- Reset mid-operation: outputs drop immediately; the next stream needs a full N-sample refill.
- Widths: popcount and `match_o` are LENGTH+1 bits. No wrap is possible because N < 2^(LENGTH+1).

## Structure
- Shared package `m_seq_pkg`:
  - Defaults for POLYNOME, SEED, N and HOLD.
  - Function `gen_mseq(poly, seed)` returning the N-bit reference, used at elaboration.
  - State enum `corr_state_t` {IDLE, FILL, TRACK, LOCK}.
- One sub-module, `popcount_reg`: N-bit input, registered LENGTH+1-bit count output, giving the one-cycle correlation stage.
- The top module holds the hold counter, window, fill/lockout counters and FSM.

## Test plan
- Reset: `rstn`=0 mid-stream for 2 cycles → all outputs 0 within the same cycle, state IDLE.
- Aligned sequence: generator chips from SEED 6'b101010, HOLD=3, `chip_en_i` continuous → after the 63rd sample, `match_o`=63 and `detect_o`=1 with `inverted_o`=0, at sample+2.
- Inverted stream: same stimulus with `chip_i` negated → `match_o`=0, `detect_o`=1, `inverted_o`=1.
- Lockout: two back-to-back sequences → exactly one `detect_o` per 63 samples. Off-peak `match_o` values are 31 or 32 (M-sequence autocorrelation).
- Noise: 3 chips flipped → `match_o`=60, detect fires. 4 chips flipped → `match_o`=59, no detect.
- Dropout: `chip_en_i` low after 40 samples, then restarted → no `match_valid_o` until 63 new samples have been taken; detection on the restarted full sequence.
